// File: rtl/mem_port_arbiter.sv
// Shares one memory read/write port between the IFU (read-only) and the execution
// unit (read/write). One transaction is outstanding at a time, and read data returns after a fixed latency.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12,
    parameter int RD_LATENCY = 1,
    parameter int MAX_WAIT   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ifu_rd_req,
    input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    output logic                  ifu_rd_gnt,
    output logic                  ifu_rd_valid,
    output logic [DATA_WIDTH-1:0] ifu_rd_data,
    input  logic                  exe_rd_req,
    input  logic                  exe_wr_req,
    input  logic [ADDR_WIDTH-1:0] exe_addr,
    input  logic [DATA_WIDTH-1:0] exe_wr_data,
    output logic                  exe_gnt,
    output logic                  exe_rd_valid,
    output logic [DATA_WIDTH-1:0] exe_rd_data,
    output logic                  exe_wr_done,
    output logic                  mem_rd_req,
    output logic                  mem_wr_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  proto_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [2:0] WAIT_LOAD  = 3'(RD_LATENCY - 1);
    localparam logic [3:0] STARVE_MAX = 4'(MAX_WAIT);

    logic [1:0] state;
    logic [2:0] wait_cnt;
    logic [3:0] starve_cnt;
    logic       owner_ifu;
    logic       op_wr;

    logic any_req;
    logic ifu_wins;
    logic exe_wr_wins;

    // The IFU wins only when exec is idle, or once it has lost MAX_WAIT arbitrations in a row.
    always_comb begin
        any_req     = ifu_rd_req | exe_rd_req | exe_wr_req;
        ifu_wins    = ifu_rd_req & ((starve_cnt == STARVE_MAX) | ~(exe_rd_req | exe_wr_req));
        exe_wr_wins = exe_wr_req & ~ifu_wins;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            starve_cnt   <= '0;
            owner_ifu    <= 1'b0;
            op_wr        <= 1'b0;
            ifu_rd_gnt   <= 1'b0;
            ifu_rd_valid <= 1'b0;
            ifu_rd_data  <= '0;
            exe_gnt      <= 1'b0;
            exe_rd_valid <= 1'b0;
            exe_rd_data  <= '0;
            exe_wr_done  <= 1'b0;
            mem_rd_req   <= 1'b0;
            mem_wr_req   <= 1'b0;
            mem_addr     <= '0;
            mem_wr_data  <= '0;
            proto_err    <= 1'b0;
        end else begin
            ifu_rd_gnt   <= 1'b0;
            ifu_rd_valid <= 1'b0;
            exe_gnt      <= 1'b0;
            exe_rd_valid <= 1'b0;
            exe_wr_done  <= 1'b0;
            mem_rd_req   <= 1'b0;
            mem_wr_req   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (exe_rd_req && exe_wr_req) begin
                        proto_err <= 1'b1;
                    end
                    if (any_req) begin
                        state      <= S_ISSUE;
                        owner_ifu  <= ifu_wins;
                        op_wr      <= exe_wr_wins;
                        mem_rd_req <= ~exe_wr_wins;
                        mem_wr_req <= exe_wr_wins;
                        mem_addr   <= ifu_wins ? ifu_rd_addr : exe_addr;
                        ifu_rd_gnt <= ifu_wins;
                        exe_gnt    <= ~ifu_wins;
                        if (exe_wr_wins) begin
                            mem_wr_data <= exe_wr_data;
                        end
                    end
                    // Any remaining IFU request here means exec just beat it.
                    if (ifu_wins || !ifu_rd_req) begin
                        starve_cnt <= '0;
                    end else if (starve_cnt != STARVE_MAX) begin
                        starve_cnt <= starve_cnt + 4'd1;
                    end
                end
                S_ISSUE: begin
                    if (op_wr) begin
                        state       <= S_RESP;
                        exe_wr_done <= 1'b1;
                    end else begin
                        state    <= S_WAIT;
                        wait_cnt <= WAIT_LOAD;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state <= S_RESP;
                        if (owner_ifu) begin
                            ifu_rd_data  <= mem_rd_data;
                            ifu_rd_valid <= 1'b1;
                        end else begin
                            exe_rd_data  <= mem_rd_data;
                            exe_rd_valid <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
